// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER multicycle PC sequencer: opcodes, MRET word,
// sequencer states and next-PC source selects.
package otter_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [31:0] MretInstr = 32'h30200073;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWb    = 3'd3,
    StIntr  = 3'd4
  } seq_state_t;

  typedef enum logic [2:0] {
    PcSelPlus4  = 3'd0,
    PcSelJal    = 3'd1,
    PcSelJalr   = 3'd2,
    PcSelBranch = 3'd3,
    PcSelMtvec  = 3'd4,
    PcSelMepc   = 3'd5
  } pc_sel_t;

endpackage

// File: rtl/otter_pc_sequencer_branch_cond_gen.sv
// Branch-taken decode from funct3 and the rs1/rs2 comparator results.
module branch_cond_gen (
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = br_eq_i;
      3'b001:  taken_o = ~br_eq_i;
      3'b100:  taken_o = br_lt_i;
      3'b101:  taken_o = ~br_lt_i;
      3'b110:  taken_o = br_ltu_i;
      3'b111:  taken_o = ~br_ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_pc_sequencer.sv
// Multicycle OTTER control: walks each instruction through FETCH/EXEC/(WB)/(INTR)
// and drives the PC register's load value, load enable and clear.
module otter_pc_sequencer
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IR,
  input  logic [31:0] PC,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        INTR,
  input  logic        CSR_MIE,
  output logic [31:0] PC_Din,
  output logic        PC_WRITE,
  output logic        PC_RST,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        REG_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC,
  output logic [2:0]  STATE
);

  seq_state_t  state_q, state_d;
  pc_sel_t     pc_sel;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        br_taken;
  logic        intr_req;
  logic [31:0] pc_plus4;
  logic [31:0] pc_mux;

  logic pc_write, mem_rden1, mem_rden2, mem_we2, reg_we, int_taken, mret_exec;

  assign opcode   = IR[6:0];
  assign funct3   = IR[14:12];
  assign intr_req = INTR & CSR_MIE;
  assign pc_plus4 = PC + 32'd4;

  branch_cond_gen u_branch_cond_gen (
    .funct3_i (funct3),
    .br_eq_i  (BR_EQ),
    .br_lt_i  (BR_LT),
    .br_ltu_i (BR_LTU),
    .taken_o  (br_taken)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_sel    = PcSelPlus4;
    pc_write  = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    reg_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        mem_rden1 = 1'b1;
        state_d   = StExec;
      end
      StExec: begin
        if (opcode == OpcLoad) begin
          mem_rden2 = 1'b1;
          state_d   = StWb;
        end else begin
          pc_write = 1'b1;
          state_d  = intr_req ? StIntr : StFetch;
          case (opcode)
            OpcLui, OpcAuipc, OpcOp, OpcOpImm: reg_we = 1'b1;
            OpcJal: begin
              reg_we = 1'b1;
              pc_sel = PcSelJal;
            end
            OpcJalr: begin
              reg_we = 1'b1;
              pc_sel = PcSelJalr;
            end
            OpcStore: mem_we2 = 1'b1;
            OpcBranch: begin
              if (br_taken) pc_sel = PcSelBranch;
            end
            OpcSystem: begin
              reg_we = (funct3 != 3'b000);
              if (IR == MretInstr) begin
                mret_exec = 1'b1;
                pc_sel    = PcSelMepc;
              end
            end
            default: ;
          endcase
        end
      end
      StWb: begin
        reg_we   = 1'b1;
        pc_write = 1'b1;
        state_d  = intr_req ? StIntr : StFetch;
      end
      StIntr: begin
        pc_write  = 1'b1;
        int_taken = 1'b1;
        pc_sel    = PcSelMtvec;
        state_d   = StFetch;
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    pc_mux = pc_plus4;
    case (pc_sel)
      PcSelJal:    pc_mux = JAL_TGT;
      PcSelJalr:   pc_mux = JALR_TGT;
      PcSelBranch: pc_mux = BRANCH_TGT;
      PcSelMtvec:  pc_mux = MTVEC;
      PcSelMepc:   pc_mux = MEPC;
      default:     pc_mux = pc_plus4;
    endcase
  end

  // Reset overrides every enable so an aborted instruction commits nothing.
  assign PC_RST    = ~RST_N;
  assign PC_WRITE  = RST_N & pc_write;
  assign MEM_RDEN1 = RST_N & mem_rden1;
  assign MEM_RDEN2 = RST_N & mem_rden2;
  assign MEM_WE2   = RST_N & mem_we2;
  assign REG_WE    = RST_N & reg_we;
  assign INT_TAKEN = RST_N & int_taken;
  assign MRET_EXEC = RST_N & mret_exec;
  assign PC_Din    = !RST_N ? 32'd0 : (pc_write ? pc_mux : pc_plus4);
  assign STATE     = state_q;

endmodule
